// File: rtl/stack_frame_controller.sv
// Stack/frame sequencer: turns PUSH/POP/ENTER/LEAVE commands into one memory
// access plus the matching stack-pointer and base-pointer updates.
module stack_frame_controller #(
    parameter logic [15:0] STACK_BASE  = 16'h0000,
    parameter logic [15:0] STACK_LIMIT = 16'h00FF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_error,
    output logic [1:0]  sp_op,
    output logic [15:0] sp_write_data,
    input  logic [15:0] sp_data,
    output logic        bp_write,
    output logic [15:0] bp_write_data,
    input  logic [15:0] bp_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);
    typedef enum logic [1:0] {IDLE, LOADSP, MEM, RESP} state_t;

    localparam logic [1:0] OP_PUSH  = 2'd0;
    localparam logic [1:0] OP_POP   = 2'd1;
    localparam logic [1:0] OP_ENTER = 2'd2;
    localparam logic [1:0] OP_LEAVE = 2'd3;

    localparam logic [1:0] SP_INC  = 2'd0;
    localparam logic [1:0] SP_DEC  = 2'd1;
    localparam logic [1:0] SP_LOAD = 2'd2;
    localparam logic [1:0] SP_HOLD = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        err_q, err_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        reject;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_PUSH;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        err_d         = err_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rsp_data_d    = rsp_data_q;
        reject        = 1'b0;
        sp_op         = SP_HOLD;
        sp_write_data = '0;
        bp_write      = 1'b0;
        bp_write_data = '0;
        mem_req       = 1'b0;

        // Strobes are suppressed while reset is held so an aborted command
        // cannot touch SP/BP even if an ack coincides with reset.
        if (!reset) begin
            case (state_q)
                IDLE: if (cmd_valid) begin
                    op_d        = cmd_op;
                    rsp_data_d  = '0;
                    mem_wdata_d = cmd_data;
                    case (cmd_op)
                        OP_PUSH: begin
                            mem_addr_d = sp_data;
                            mem_we_d   = 1'b1;
                            reject     = (sp_data == STACK_LIMIT);
                        end
                        OP_ENTER: begin
                            mem_addr_d  = sp_data;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = bp_data;
                            reject      = (sp_data == STACK_LIMIT);
                        end
                        OP_POP: begin
                            mem_addr_d = sp_data - 16'd1;
                            mem_we_d   = 1'b0;
                            reject     = (sp_data == STACK_BASE);
                        end
                        default: begin
                            mem_addr_d = bp_data - 16'd1;
                            mem_we_d   = 1'b0;
                            reject     = (bp_data == STACK_BASE);
                        end
                    endcase
                    err_d = reject;
                    if (reject)                 state_d = RESP;
                    else if (cmd_op == OP_LEAVE) state_d = LOADSP;
                    else                        state_d = MEM;
                end
                LOADSP: begin
                    sp_op         = SP_LOAD;
                    sp_write_data = bp_data;
                    state_d       = MEM;
                end
                MEM: begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        state_d = RESP;
                        case (op_q)
                            OP_PUSH: sp_op = SP_INC;
                            OP_ENTER: begin
                                sp_op         = SP_INC;
                                bp_write      = 1'b1;
                                bp_write_data = sp_data + 16'd1;
                            end
                            OP_POP: begin
                                sp_op      = SP_DEC;
                                rsp_data_d = mem_rdata;
                            end
                            default: begin
                                sp_op         = SP_DEC;
                                bp_write      = 1'b1;
                                bp_write_data = mem_rdata;
                                rsp_data_d    = mem_rdata;
                            end
                        endcase
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign cmd_ready = reset || (state_q == IDLE);
    assign rsp_valid = !reset && (state_q == RESP);
    assign rsp_error = rsp_valid && err_q;
    assign rsp_data  = rsp_data_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_stack_frame_controller.sv
// Bench for stack_frame_controller: vector table with a response scoreboard,
// an SP/BP register model driven by the strobes, and a reset-abort sequence.
module tb_stack_frame_controller;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_data = '0;
    logic        cmd_ready, rsp_valid, rsp_error, bp_write, mem_req, mem_we;
    logic [15:0] rsp_data, sp_write_data, bp_write_data, mem_addr, mem_wdata;
    logic [1:0]  sp_op;
    logic [15:0] sp_data = '0, bp_data = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int nchk = 0;
    int npass = 0;

    always #5 clock = ~clock;

    stack_frame_controller dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .sp_op(sp_op), .sp_write_data(sp_write_data), .sp_data(sp_data),
        .bp_write(bp_write), .bp_write_data(bp_write_data), .bp_data(bp_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data, sp, bp;
        int          wt;
        logic [15:0] rdata, addr;
        logic        we;
        logic [15:0] wdata;
        logic        err;
        logic [15:0] rsp, sp_after, bp_after;
        int          lat, nsp;
    } vec_t;

    typedef struct {
        logic        err;
        logic [15:0] data;
    } rsp_t;

    rsp_t sb[$];
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc, waited, nreq, nsp;
        logic got, bw;
        logic [1:0] so;
        logic [15:0] swd, bwd;
        rsp_t r;
        @(negedge clock);
        sp_data = v.sp; bp_data = v.bp;
        cmd_op = v.op; cmd_data = v.data; cmd_valid = 1'b1;
        #1 chk($sformatf("v%0d_ready", idx), cmd_ready, 1);
        sb.push_back('{v.err, v.rsp});
        @(posedge clock); #1 cmd_valid = 1'b0;
        cyc = 0; waited = 0; nreq = 0; nsp = 0; got = 1'b0;
        while (!got && cyc < 50) begin
            @(negedge clock);
            cyc++;
            if (mem_req) begin
                mem_ack   = (waited == v.wt);
                mem_rdata = mem_ack ? v.rdata : 16'hDEAD;
                waited++;
            end
            #1;
            if (mem_req) begin
                nreq++;
                chk($sformatf("v%0d_addr", idx), mem_addr, v.addr);
                chk($sformatf("v%0d_we", idx), mem_we, v.we);
                if (v.we) chk($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
            end
            if (sp_op != 2'd3) nsp++;
            if (sp_op == 2'd2) chk($sformatf("v%0d_ldsp", idx), sp_write_data, v.bp);
            if (rsp_valid) begin
                got = 1'b1;
                chk($sformatf("v%0d_latency", idx), cyc, v.lat);
                if (sb.size() == 0) chk($sformatf("v%0d_sb_empty", idx), 0, 1);
                else begin
                    r = sb.pop_front();
                    chk($sformatf("v%0d_rsp_err", idx), rsp_error, r.err);
                    chk($sformatf("v%0d_rsp_data", idx), rsp_data, r.data);
                end
            end
            so = sp_op; swd = sp_write_data; bw = bp_write; bwd = bp_write_data;
            @(posedge clock); #1;
            case (so)
                2'd0: sp_data = sp_data + 16'd1;
                2'd1: sp_data = sp_data - 16'd1;
                2'd2: sp_data = swd;
                default: ;
            endcase
            if (bw) bp_data = bwd;
            mem_ack = 1'b0;
        end
        if (!got) chk($sformatf("v%0d_timeout", idx), 0, 1);
        chk($sformatf("v%0d_nreq", idx), nreq, v.err ? 0 : v.wt + 1);
        chk($sformatf("v%0d_nsp", idx), nsp, v.nsp);
        chk($sformatf("v%0d_sp_after", idx), sp_data, v.sp_after);
        chk($sformatf("v%0d_bp_after", idx), bp_data, v.bp_after);
    endtask

    initial begin
        //          op     data      sp        bp        wt rdata     addr      we    wdata     err   rsp       sp_after  bp_after  lat nsp
        vecs[0]  = '{2'd0, 16'hBEEF, 16'h0010, 16'h0000, 0, 16'h0000, 16'h0010, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 16'h0011, 16'h0000, 2, 1};
        vecs[1]  = '{2'd1, 16'h0000, 16'h0011, 16'h0000, 3, 16'hBEEF, 16'h0010, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 16'h0010, 16'h0000, 5, 1};
        vecs[2]  = '{2'd2, 16'h0000, 16'h0020, 16'h0008, 0, 16'h0000, 16'h0020, 1'b1, 16'h0008, 1'b0, 16'h0000, 16'h0021, 16'h0021, 2, 1};
        vecs[3]  = '{2'd3, 16'h0000, 16'h0030, 16'h0021, 0, 16'h0008, 16'h0020, 1'b0, 16'h0000, 1'b0, 16'h0008, 16'h0020, 16'h0008, 3, 2};
        vecs[4]  = '{2'd0, 16'h1111, 16'h00FF, 16'h0005, 0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h00FF, 16'h0005, 1, 0};
        vecs[5]  = '{2'd1, 16'h0000, 16'h0000, 16'h0005, 0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0000, 16'h0005, 1, 0};
        vecs[6]  = '{2'd3, 16'h0000, 16'h0030, 16'h0000, 0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h0030, 16'h0000, 1, 0};
        vecs[7]  = '{2'd2, 16'h0000, 16'h00FF, 16'h0010, 0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h00FF, 16'h0010, 1, 0};
        vecs[8]  = '{2'd1, 16'h0000, 16'h0080, 16'h0000, 1, 16'h1234, 16'h007F, 1'b0, 16'h0000, 1'b0, 16'h1234, 16'h007F, 16'h0000, 3, 1};
        vecs[9]  = '{2'd0, 16'hA5A5, 16'h00FE, 16'h0000, 2, 16'h0000, 16'h00FE, 1'b1, 16'hA5A5, 1'b0, 16'h0000, 16'h00FF, 16'h0000, 4, 1};
        vecs[10] = '{2'd3, 16'h0000, 16'h0050, 16'h0040, 2, 16'h0030, 16'h003F, 1'b0, 16'h0000, 1'b0, 16'h0030, 16'h003F, 16'h0030, 5, 2};

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_error", rsp_error, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_sp_op", sp_op, 3);
        chk("rst_sp_wdata", sp_write_data, 0);
        chk("rst_bp_write", bp_write, 0);
        chk("rst_bp_wdata", bp_write_data, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        reset = 1'b0;

        // Stray ack while idle must not move anything.
        @(negedge clock); mem_ack = 1'b1;
        #1 chk("idle_ack_sp_op", sp_op, 3);
        chk("idle_ack_rsp", rsp_valid, 0);
        @(posedge clock); #1 mem_ack = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // Reset while waiting for memory aborts the push.
        @(negedge clock);
        sp_data = 16'h0040; cmd_op = 2'd0; cmd_data = 16'h7777; cmd_valid = 1'b1;
        @(posedge clock); #1 cmd_valid = 1'b0;
        @(negedge clock); #1 chk("abort_mem_req_before", mem_req, 1);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock); #1 chk("abort_mem_req", mem_req, 0);
        chk("abort_ready", cmd_ready, 1);
        for (int k = 0; k < 2; k++) begin
            mem_ack = 1'b1;
            #1 chk($sformatf("abort_late_sp_op%0d", k), sp_op, 3);
            chk($sformatf("abort_late_bp_write%0d", k), bp_write, 0);
            chk($sformatf("abort_late_rsp%0d", k), rsp_valid, 0);
            @(negedge clock);
        end
        mem_ack = 1'b0;

        run_vec(vecs[0], 11);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
